// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Fetch stage in front of the execution unit. Walks the PC through instruction
//   memory over a single-outstanding req/ack read port. Two-word instructions
//   (AU-immediate, LDI, STI) are merged with their immediate into one entry.
//   Entries are buffered in a small FIFO and handed to the execution unit on a
//   valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, start_pc       1-cycle pulse: begin fetching at start_pc
//   pc_limit              fetch stops once the opcode-word PC >= pc_limit
//   redirect, redirect_pc 1-cycle pulse: flush FIFO and restart at redirect_pc
//   mem_rd_req/addr       read request / address (held until ack)
//   mem_rd_ack/data       read completion and data
//   ins_valid/ready       head-entry handshake towards the execution unit
//   ins_word/imm/two_word/pc  head-entry fields (0 when the FIFO is empty)
//   done                  DONE state, FIFO empty, no read outstanding
//
// Configuration:
//   IFU_PERF_EN  when defined, adds perf_insn_cnt (entries popped) and
//                perf_stall_cnt (ready but nothing valid while fetching);
//                both saturate at 16'hFFFF and clear on reset only.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int               WORD_W     = 16,
  parameter int               ADDR_W     = 8,
  parameter int               OPC_W      = 4,
  parameter logic [OPC_W-1:0] LDI_OPC    = 4'h1,
  parameter logic [OPC_W-1:0] STI_OPC    = 4'h3,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] pc_limit,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [WORD_W-1:0] ins_word,
  output logic [WORD_W-1:0] ins_imm,
  output logic              ins_two_word,
  output logic [ADDR_W-1:0] ins_pc,
`ifdef IFU_PERF_EN
  output logic [15:0]       perf_insn_cnt,
  output logic [15:0]       perf_stall_cnt,
`endif
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH_OP,
    S_FETCH_IMM,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] imm;
    logic              two_word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  // Control state
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_drop;     // outstanding read belongs to a flushed stream
  logic [WORD_W-1:0] r_op_word;  // opcode word waiting for its immediate
  logic [ADDR_W-1:0] r_op_pc;

  // Entry FIFO
  entry_t            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Next-state signals
  logic              w_busy;
  logic              w_flush;
  logic              w_launch;
  logic [ADDR_W-1:0] w_new_pc;
  logic              w_ack;
  logic              w_data_ok;
  logic [OPC_W-1:0]  w_rd_opc;
  logic              w_is_two;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_entry;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  state_t            w_state_nxt;
  logic              w_port_free;
  logic              w_issue;
  entry_t            w_head;

  assign w_busy   = (r_state == S_FETCH_OP) || (r_state == S_FETCH_IMM);
  // A start while fetching is treated exactly like a redirect to start_pc.
  assign w_flush  = redirect | (start & w_busy);
  assign w_launch = start & ~w_busy & ~redirect;
  assign w_new_pc = redirect ? redirect_pc : start_pc;

  assign w_ack     = r_req & mem_rd_ack;
  // Returned data is only used when it belongs to the current stream.
  assign w_data_ok = w_ack & ~r_drop & ~w_flush & w_busy;
  assign w_rd_opc  = mem_rd_data[WORD_W-1 -: OPC_W];
  assign w_is_two  = (w_rd_opc[OPC_W-1] & w_rd_opc[0]) |
                     (w_rd_opc == LDI_OPC) | (w_rd_opc == STI_OPC);

  assign w_push = w_data_ok &
                  (((r_state == S_FETCH_OP) & ~w_is_two) | (r_state == S_FETCH_IMM));
  assign w_pop  = ins_valid & ins_ready & ~w_flush;

  // The port is free after this cycle if nothing is outstanding or the
  // outstanding read completes now (back-to-back issue is allowed).
  assign w_port_free = ~r_req | w_ack;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_push_entry = '0;
    w_count_nxt  = r_count;
    w_pc_nxt     = r_pc;
    w_state_nxt  = r_state;
    w_issue      = 1'b0;

    if (r_state == S_FETCH_IMM) begin
      w_push_entry = '{word: r_op_word, imm: mem_rd_data, two_word: 1'b1, pc: r_op_pc};
    end else begin
      w_push_entry = '{word: mem_rd_data, imm: '0, two_word: 1'b0, pc: r_pc};
    end

    if (w_flush) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    if (w_flush || w_launch) begin
      w_pc_nxt    = w_new_pc;
      w_state_nxt = S_FETCH_OP;
    end else begin
      if (w_data_ok) begin
        w_pc_nxt = r_pc + ADDR_W'(1);  // wraps at the top address
      end
      case (r_state)
        S_FETCH_OP:  if (w_data_ok && w_is_two) w_state_nxt = S_FETCH_IMM;
        S_FETCH_IMM: if (w_data_ok)             w_state_nxt = S_FETCH_OP;
        default:     w_state_nxt = r_state;
      endcase
      // Stop only at an opcode-word boundary with nothing in flight.
      if (w_state_nxt == S_FETCH_OP && w_port_free && w_pc_nxt >= pc_limit) begin
        w_state_nxt = S_DONE;
      end
    end

    // The immediate read ignores pc_limit; the FIFO must have room for the
    // entry this read will eventually complete.
    if (w_port_free && w_count_nxt < FULL_CNT) begin
      if (w_state_nxt == S_FETCH_IMM) begin
        w_issue = 1'b1;
      end else if (w_state_nxt == S_FETCH_OP && w_pc_nxt < pc_limit) begin
        w_issue = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_drop    <= 1'b0;
      r_op_word <= '0;
      r_op_pc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;

      if (w_issue) begin
        r_req  <= 1'b1;
        r_addr <= w_pc_nxt;
      end else if (w_ack) begin
        r_req  <= 1'b0;
      end

      // A flushed read is still allowed to complete; its data is discarded.
      if (w_flush && r_req && !mem_rd_ack) begin
        r_drop <= 1'b1;
      end else if (w_ack) begin
        r_drop <= 1'b0;
      end

      if (w_data_ok && r_state == S_FETCH_OP && w_is_two) begin
        r_op_word <= mem_rd_data;
        r_op_pc   <= r_pc;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // NOTE: FIFO storage has no reset; the outputs are masked by ins_valid, so
  // stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_push_entry;
    end
  end

  assign w_head       = r_fifo[r_rd_ptr];
  assign ins_valid    = (r_count != '0);
  assign ins_word     = ins_valid ? w_head.word     : '0;
  assign ins_imm      = ins_valid ? w_head.imm      : '0;
  assign ins_two_word = ins_valid ? w_head.two_word : 1'b0;
  assign ins_pc       = ins_valid ? w_head.pc       : '0;

  assign mem_rd_req  = r_req;
  assign mem_rd_addr = r_addr;
  assign done        = (r_state == S_DONE) && !ins_valid && !r_req;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_insn_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_pop && perf_insn_cnt != 16'hFFFF) begin
        perf_insn_cnt <= perf_insn_cnt + 16'd1;
      end
      if (ins_ready && !ins_valid && w_busy && perf_stall_cnt != 16'hFFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit: a behavioural instruction memory with a
// programmable ack latency, a monitor that records every popped entry, an
// opcode-decode vector table, and hand-written multi-cycle sequences for FIFO
// back-pressure, redirect with a read in flight, PC wrap and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic [ADDR_W-1:0] pc_limit;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic [WORD_W-1:0] mem_rd_data;
  logic              ins_valid;
  logic              ins_ready;
  logic [WORD_W-1:0] ins_word;
  logic [WORD_W-1:0] ins_imm;
  logic              ins_two_word;
  logic [ADDR_W-1:0] ins_pc;
  logic              done;
`ifdef IFU_PERF_EN
  logic [15:0]       perf_insn_cnt;
  logic [15:0]       perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .start_pc     (start_pc),
    .pc_limit     (pc_limit),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins_word     (ins_word),
    .ins_imm      (ins_imm),
    .ins_two_word (ins_two_word),
    .ins_pc       (ins_pc),
`ifdef IFU_PERF_EN
    .perf_insn_cnt  (perf_insn_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .done         (done)
  );

  typedef struct {
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] imm;
    logic              two;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  typedef struct {
    string             name;
    logic [WORD_W-1:0] op;
    logic [WORD_W-1:0] imm;
    logic              exp_two;
  } vec_t;

  logic [WORD_W-1:0] mem [256];
  ent_t              got_q[$];
  logic [ADDR_W-1:0] req_log[$];
  int                ack_lat = 1;
  bit                resp_en = 1'b1;
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ent(input string name, input int idx, input logic [WORD_W-1:0] w,
                           input logic [WORD_W-1:0] i, input logic t, input logic [ADDR_W-1:0] p);
    if (idx < got_q.size()) begin
      check(name, {got_q[idx].word, got_q[idx].imm, got_q[idx].two, got_q[idx].pc}, {w, i, t, p});
    end else begin
      check({name, "_missing"}, got_q.size(), idx + 1);
    end
  endtask

  // Memory responder: ack arrives ack_lat cycles after a request is seen.
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        wcnt = 0;
      end else if (!rst_n) begin
        mem_rd_ack = 1'b0;
        wcnt = 0;
      end else if (mem_rd_ack) begin
        mem_rd_ack = 1'b0;
        if (mem_rd_req) begin  // back-to-back request
          wcnt = 1;
          req_log.push_back(mem_rd_addr);
        end else begin
          wcnt = 0;
        end
      end else if (mem_rd_req) begin
        if (wcnt == 0) req_log.push_back(mem_rd_addr);
        wcnt++;
        if (wcnt > ack_lat) begin
          mem_rd_ack  = 1'b1;
          mem_rd_data = mem[mem_rd_addr];
        end
      end
    end
  end

  // Entry monitor: a pop happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && ins_valid && ins_ready && !redirect) begin
      got_q.push_back('{word: ins_word, imm: ins_imm, two: ins_two_word, pc: ins_pc});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    req_log.delete();
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] lim);
    @(posedge clk);
    #1;
    start_pc = pc;
    pc_limit = lim;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check(name, done, 1'b1);
  endtask

  task automatic wait_reqs(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_log.size() >= n) break;
    end
    check(name, req_log.size(), n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"},   mem_rd_req,   1'b0);
    check({tag, "_addr"},  mem_rd_addr,  '0);
    check({tag, "_valid"}, ins_valid,    1'b0);
    check({tag, "_word"},  ins_word,     '0);
    check({tag, "_imm"},   ins_imm,      '0);
    check({tag, "_two"},   ins_two_word, 1'b0);
    check({tag, "_pc"},    ins_pc,       '0);
    check({tag, "_done"},  done,         1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{"au9", 16'h9001, 16'h1234, 1'b1};
    vecs[1] = '{"aub", 16'hB0A5, 16'h5A5A, 1'b1};
    vecs[2] = '{"auf", 16'hFFFF, 16'h0000, 1'b1};
    vecs[3] = '{"aud", 16'hD00D, 16'h7777, 1'b1};
    vecs[4] = '{"ldi", 16'h1234, 16'hCAFE, 1'b1};
    vecs[5] = '{"sti", 16'h3100, 16'h8000, 1'b1};
    vecs[6] = '{"op8", 16'h8123, 16'h0456, 1'b0};
    vecs[7] = '{"op5", 16'h5001, 16'h6002, 1'b0};
    vecs[8] = '{"ope", 16'hE00E, 16'h4444, 1'b0};
    vecs[9] = '{"op0", 16'h0000, 16'h2222, 1'b0};

    for (int a = 0; a < 256; a++) mem[a] = '0;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_pc    = '0;
    pc_limit    = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ins_ready   = 1'b0;
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;

    // Reset state
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("idle_no_req", mem_rd_req, 1'b0);
    check("idle_no_done", done, 1'b0);

    // 1: three single-word ops, limit 3
    mem[0] = 16'h0011;
    mem[1] = 16'h2022;
    mem[2] = 16'h4033;
    ins_ready = 1'b1;
    ack_lat   = 1;
    clear_logs();
    pulse_start(8'h00, 8'h03);
    wait_done(100, "t1_done");
    check("t1_entries", got_q.size(), 3);
    check_ent("t1_e0", 0, 16'h0011, 16'h0, 1'b0, 8'h00);
    check_ent("t1_e1", 1, 16'h2022, 16'h0, 1'b0, 8'h01);
    check_ent("t1_e2", 2, 16'h4033, 16'h0, 1'b0, 8'h02);
    tick(5);
    check("t1_reads", req_log.size(), 3);
    check("t1_last_addr", req_log[2], 8'h02);
    check("t1_req_idle", mem_rd_req, 1'b0);

    // 2: opcode decode table
    for (int v = 0; v < 10; v++) begin
      mem[8'h10] = vecs[v].op;
      mem[8'h11] = vecs[v].imm;
      mem[8'h12] = 16'h0ABC;
      clear_logs();
      pulse_start(8'h10, 8'h13);
      wait_done(100, {vecs[v].name, "_done"});
      if (vecs[v].exp_two) begin
        check({vecs[v].name, "_cnt"}, got_q.size(), 2);
        check_ent({vecs[v].name, "_e0"}, 0, vecs[v].op, vecs[v].imm, 1'b1, 8'h10);
        check_ent({vecs[v].name, "_e1"}, 1, 16'h0ABC, 16'h0, 1'b0, 8'h12);
      end else begin
        check({vecs[v].name, "_cnt"}, got_q.size(), 3);
        check_ent({vecs[v].name, "_e0"}, 0, vecs[v].op, 16'h0, 1'b0, 8'h10);
        check_ent({vecs[v].name, "_e1"}, 1, vecs[v].imm, 16'h0, 1'b0, 8'h11);
        check_ent({vecs[v].name, "_e2"}, 2, 16'h0ABC, 16'h0, 1'b0, 8'h12);
      end
    end

    // 3: back-pressure stops issue at FIFO_DEPTH reads
    for (int i = 0; i < 8; i++) mem[8'h20 + i] = 16'h0100 + 16'(i);
    ins_ready = 1'b0;
    clear_logs();
    pulse_start(8'h20, 8'h28);
    tick(30);
    check("t3_reads_full", req_log.size(), 4);
    check("t3_req_idle", mem_rd_req, 1'b0);
    check("t3_head_valid", ins_valid, 1'b1);
    check("t3_head_pc", ins_pc, 8'h20);
    ins_ready = 1'b1;
    wait_done(200, "t3_done");
    check("t3_entries", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_ent($sformatf("t3_e%0d", i), i, 16'h0100 + 16'(i), 16'h0, 1'b0, 8'(8'h20 + i));
    end

    // 4: redirect while a 3-cycle read is outstanding
    for (int i = 0; i < 4; i++) mem[8'h30 + i] = 16'h0300 + 16'(i);
    mem[8'h40] = 16'h0440;
    mem[8'h41] = 16'h0441;
    ack_lat   = 3;
    ins_ready = 1'b0;
    clear_logs();
    pulse_start(8'h30, 8'h42);
    wait_reqs(2, 50, "t4_second_req");
    check("t4_fifo_before", ins_valid, 1'b1);
    @(posedge clk);
    #1;
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check("t4_fifo_flushed", ins_valid, 1'b0);
    check("t4_req_held", mem_rd_req, 1'b1);
    check("t4_addr_held", mem_rd_addr, 8'h31);
    ins_ready = 1'b1;
    wait_done(200, "t4_done");
    check("t4_entries", got_q.size(), 2);
    check_ent("t4_e0", 0, 16'h0440, 16'h0, 1'b0, 8'h40);
    check_ent("t4_e1", 1, 16'h0441, 16'h0, 1'b0, 8'h41);
    check("t4_next_addr", req_log[2], 8'h40);

    // Boundary: start at the top address with limit equal to it issues nothing
    ack_lat = 1;
    clear_logs();
    pulse_start(8'hFF, 8'hFF);
    wait_done(20, "top_limit_done");
    check("top_limit_reads", req_log.size(), 0);

    // 5: PC wrap. An opcode word at 8'hFF can never pass PC < pc_limit, so the
    // two-word op sits at 8'hFE with its immediate at the top address.
    mem[8'hFE] = 16'h1055;  // LDI
    mem[8'hFF] = 16'hBEEF;
    mem[8'h00] = 16'h3077;  // STI
    mem[8'h01] = 16'h1111;
    ack_lat   = 3;
    ins_ready = 1'b1;
    clear_logs();
    pulse_start(8'hFE, 8'hFF);
    wait_reqs(4, 100, "t5_reads");
    check("t5_entries", got_q.size(), 1);
    check_ent("t5_e0", 0, 16'h1055, 16'hBEEF, 1'b1, 8'hFE);
    check("t5_wrap_addr", req_log[2], 8'h00);
    check("t5_imm_addr", req_log[3], 8'h01);
    check("t5_imm_req", mem_rd_req, 1'b1);

    // 6: asynchronous reset in FETCH_IMM with the immediate read in flight
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    tick(2);
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    mem_rd_ack  = 1'b1;   // late ack from the abandoned read
    mem_rd_data = 16'h0999;
    @(posedge clk);
    #1;
    mem_rd_ack = 1'b0;
    resp_en    = 1'b1;
    tick(3);
    check("t6_idle_req", mem_rd_req, 1'b0);
    check("t6_idle_valid", ins_valid, 1'b0);
    check("t6_idle_done", done, 1'b0);
    check("t6_no_entry", got_q.size(), 1);
    mem[8'h50] = 16'h0550;
    clear_logs();
    pulse_start(8'h50, 8'h51);
    wait_done(100, "t6_restart_done");
    check("t6_restart_cnt", got_q.size(), 1);
    check_ent("t6_restart_e0", 0, 16'h0550, 16'h0, 1'b0, 8'h50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
